// File: rtl/vision_pkg.sv
// Shared constants and FSM encoding for the tracking pipeline's centroid stage.
package vision_pkg;

    localparam int H_ACTIVE_DEF = 1024;
    localparam int V_ACTIVE_DEF = 768;

    localparam int CNT_W = 20;
    localparam int SUM_W = 30;
    localparam int X_W   = 11;
    localparam int Y_W   = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV_X = 2'd1,
        ST_DIV_Y = 2'd2,
        ST_DONE  = 2'd3
    } cen_state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle. done/quotient are valid in the last
// iteration cycle, so a new start may be issued in that same cycle.
module seq_divider
    import vision_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);

    localparam int STEP_W = $clog2(SUM_W);

    logic [CNT_W-1:0]  rem_r;
    logic [CNT_W-1:0]  divisor_r;
    logic [SUM_W-1:0]  quo_r;
    logic [STEP_W-1:0] step_r;
    logic              active_r;

    logic [CNT_W:0]    shifted_s;
    logic [CNT_W:0]    diff_s;
    logic              ge_s;
    logic [CNT_W-1:0]  rem_nx_s;
    logic [SUM_W-1:0]  quo_nx_s;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        shifted_s = {rem_r, quo_r[SUM_W-1]};
        diff_s    = shifted_s - {1'b0, divisor_r};
        ge_s      = (shifted_s >= {1'b0, divisor_r});
        if (ge_s) begin
            rem_nx_s = diff_s[CNT_W-1:0];
        end else begin
            rem_nx_s = shifted_s[CNT_W-1:0];
        end
        quo_nx_s = {quo_r[SUM_W-2:0], ge_s};
    end

    assign done     = active_r && (step_r == STEP_W'(SUM_W - 1));
    assign quotient = quo_nx_s;

    // Operand load on start, otherwise iterate while active.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rem_r     <= {CNT_W{1'b0}};
            divisor_r <= {CNT_W{1'b0}};
            quo_r     <= {SUM_W{1'b0}};
            step_r    <= {STEP_W{1'b0}};
            active_r  <= 1'b0;
        end else if (start) begin
            rem_r     <= {CNT_W{1'b0}};
            divisor_r <= divisor;
            quo_r     <= dividend;
            step_r    <= {STEP_W{1'b0}};
            active_r  <= 1'b1;
        end else if (active_r) begin
            rem_r    <= rem_nx_s;
            quo_r    <= quo_nx_s;
            step_r   <= step_r + STEP_W'(1);
            active_r <= !done;
        end
    end

endmodule

// File: rtl/blob_centroid.sv
// Per-frame centroid of the eroded mask; accumulates the next frame while dividing.
// Optional bounding-box outputs are built when CENTROID_BBOX_EN is defined.
module blob_centroid
    import vision_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int PIXEL_LAG = 1,
    parameter int MIN_COUNT = 64
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [X_W-1:0] hcount,
    input  logic [Y_W-1:0] vcount,
    input  logic           pixel,
    output logic [X_W-1:0] centroid_x,
    output logic [Y_W-1:0] centroid_y,
    output logic           found,
    output logic           valid,
    output logic           busy,
    output logic           overrun
`ifdef CENTROID_BBOX_EN
    ,
    output logic [X_W-1:0] bbox_xmin,
    output logic [X_W-1:0] bbox_xmax,
    output logic [Y_W-1:0] bbox_ymin,
    output logic [Y_W-1:0] bbox_ymax
`endif
);

    logic [X_W-1:0]   h_pipe_r [PIXEL_LAG];
    logic [Y_W-1:0]   v_pipe_r [PIXEL_LAG];
    logic [X_W-1:0]   hd_s;
    logic [Y_W-1:0]   vd_s;
    logic             armed_r, end_prev_r;
    logic             frame_start_s, end_cond_s, frame_end_s, qual_s;
    logic [CNT_W-1:0] cnt_r, cnt_snap_r;
    logic [SUM_W-1:0] sx_r, sy_r, sy_snap_r;
    logic [X_W-1:0]   qx_r;
    cen_state_t       state_r, state_nx_s;
    logic             cnt_ok_s, accept_s, go_div_s, busy_state_s, publish_s;
    logic             div_start_s, div_done_s;
    logic [SUM_W-1:0] div_dividend_s, div_quotient_s;
    logic [CNT_W-1:0] div_divisor_s;
    logic             valid_nx_s, busy_nx_s, found_nx_s, overrun_nx_s;
    logic [X_W-1:0]   cx_nx_s;
    logic [Y_W-1:0]   cy_nx_s;
    logic             unused_quo_s;

    // Coordinate delay line aligning hcount/vcount with the lagging pixel bit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < PIXEL_LAG; i++) begin
                h_pipe_r[i] <= {X_W{1'b0}};
                v_pipe_r[i] <= {Y_W{1'b0}};
            end
        end else begin
            h_pipe_r[0] <= hcount;
            v_pipe_r[0] <= vcount;
            for (int i = 1; i < PIXEL_LAG; i++) begin
                h_pipe_r[i] <= h_pipe_r[i-1];
                v_pipe_r[i] <= v_pipe_r[i-1];
            end
        end
    end

    assign hd_s          = h_pipe_r[PIXEL_LAG-1];
    assign vd_s          = v_pipe_r[PIXEL_LAG-1];
    assign frame_start_s = (hd_s == {X_W{1'b0}}) && (vd_s == {Y_W{1'b0}});
    assign end_cond_s    = (hd_s == {X_W{1'b0}}) && (vd_s == Y_W'(V_ACTIVE));
    assign frame_end_s   = end_cond_s && !end_prev_r;
    assign qual_s        = armed_r && pixel && (hd_s < X_W'(H_ACTIVE)) && (vd_s < Y_W'(V_ACTIVE));
    assign busy_state_s  = (state_r == ST_DIV_X) || (state_r == ST_DIV_Y);
    assign cnt_ok_s      = (cnt_r >= CNT_W'(MIN_COUNT)) && (cnt_r != {CNT_W{1'b0}});
    assign accept_s      = frame_end_s && (state_r == ST_IDLE);
    assign go_div_s      = accept_s && cnt_ok_s;
    assign publish_s     = (state_r == ST_DIV_Y) && div_done_s;
    assign unused_quo_s  = ^div_quotient_s[SUM_W-1:X_W];

    // Arming, frame-end edge detect, accumulators and snapshot registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            armed_r    <= 1'b0;
            end_prev_r <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            sx_r       <= {SUM_W{1'b0}};
            sy_r       <= {SUM_W{1'b0}};
            cnt_snap_r <= {CNT_W{1'b0}};
            sy_snap_r  <= {SUM_W{1'b0}};
        end else begin
            armed_r    <= armed_r || frame_start_s;
            end_prev_r <= end_cond_s;
            if (frame_end_s) begin
                cnt_r <= {CNT_W{1'b0}};
                sx_r  <= {SUM_W{1'b0}};
                sy_r  <= {SUM_W{1'b0}};
            end else if (qual_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
                sx_r  <= sx_r + SUM_W'(hd_s);
                sy_r  <= sy_r + SUM_W'(vd_s);
            end
            if (accept_s) begin
                cnt_snap_r <= cnt_r;
                sy_snap_r  <= sy_r;
            end
        end
    end

    // Divider is fed live sums at frame end (x), then the y snapshot when x finishes.
    always_comb begin
        div_start_s = go_div_s || ((state_r == ST_DIV_X) && div_done_s);
        if (state_r == ST_DIV_X) begin
            div_dividend_s = sy_snap_r;
            div_divisor_s  = cnt_snap_r;
        end else begin
            div_dividend_s = sx_r;
            div_divisor_s  = cnt_r;
        end
    end

    seq_divider u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start_s),
        .dividend (div_dividend_s),
        .divisor  (div_divisor_s),
        .done     (div_done_s),
        .quotient (div_quotient_s)
    );

    // FSM state register plus x-quotient hold register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            qx_r    <= {X_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            if ((state_r == ST_DIV_X) && div_done_s) begin
                qx_r <= div_quotient_s[X_W-1:0];
            end
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_end_s) begin
                    state_nx_s = cnt_ok_s ? ST_DIV_X : ST_DONE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DIV_X: state_nx_s = div_done_s ? ST_DIV_Y : ST_DIV_X;
            ST_DIV_Y: state_nx_s = div_done_s ? ST_DONE : ST_DIV_Y;
            ST_DONE:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values for the registered outputs, aligned to state entry.
    always_comb begin
        valid_nx_s = 1'b0;
        busy_nx_s  = 1'b0;
        found_nx_s = found;
        case (state_nx_s)
            ST_DONE: begin
                valid_nx_s = 1'b1;
                found_nx_s = (state_r == ST_DIV_Y);
            end
            ST_DIV_X, ST_DIV_Y: busy_nx_s = 1'b1;
            default:            busy_nx_s = 1'b0;
        endcase
        if (publish_s) begin
            cx_nx_s = qx_r;
            cy_nx_s = div_quotient_s[Y_W-1:0];
        end else begin
            cx_nx_s = centroid_x;
            cy_nx_s = centroid_y;
        end
        if (frame_end_s && busy_state_s) begin
            overrun_nx_s = 1'b1;
        end else begin
            overrun_nx_s = overrun;
        end
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            centroid_x <= {X_W{1'b0}};
            centroid_y <= {Y_W{1'b0}};
            found      <= 1'b0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            centroid_x <= cx_nx_s;
            centroid_y <= cy_nx_s;
            found      <= found_nx_s;
            valid      <= valid_nx_s;
            busy       <= busy_nx_s;
            overrun    <= overrun_nx_s;
        end
    end

`ifdef CENTROID_BBOX_EN
    logic [X_W-1:0] xmin_r, xmax_r, xmin_snap_r, xmax_snap_r;
    logic [Y_W-1:0] ymin_r, ymax_r, ymin_snap_r, ymax_snap_r;

    // Running extents, snapshot at accepted frame end, published with the centroid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            xmin_r      <= {X_W{1'b1}};
            xmax_r      <= {X_W{1'b0}};
            ymin_r      <= {Y_W{1'b1}};
            ymax_r      <= {Y_W{1'b0}};
            xmin_snap_r <= {X_W{1'b0}};
            xmax_snap_r <= {X_W{1'b0}};
            ymin_snap_r <= {Y_W{1'b0}};
            ymax_snap_r <= {Y_W{1'b0}};
            bbox_xmin   <= {X_W{1'b0}};
            bbox_xmax   <= {X_W{1'b0}};
            bbox_ymin   <= {Y_W{1'b0}};
            bbox_ymax   <= {Y_W{1'b0}};
        end else begin
            if (frame_end_s) begin
                xmin_r <= {X_W{1'b1}};
                xmax_r <= {X_W{1'b0}};
                ymin_r <= {Y_W{1'b1}};
                ymax_r <= {Y_W{1'b0}};
            end else if (qual_s) begin
                xmin_r <= (hd_s < xmin_r) ? hd_s : xmin_r;
                xmax_r <= (hd_s > xmax_r) ? hd_s : xmax_r;
                ymin_r <= (vd_s < ymin_r) ? vd_s : ymin_r;
                ymax_r <= (vd_s > ymax_r) ? vd_s : ymax_r;
            end
            if (accept_s) begin
                xmin_snap_r <= xmin_r;
                xmax_snap_r <= xmax_r;
                ymin_snap_r <= ymin_r;
                ymax_snap_r <= ymax_r;
            end
            if (publish_s) begin
                bbox_xmin <= xmin_snap_r;
                bbox_xmax <= xmax_snap_r;
                bbox_ymin <= ymin_snap_r;
                bbox_ymax <= ymax_snap_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_blob_centroid.sv
// Directed bench for blob_centroid: two instances (MIN_COUNT 64 and 1) share one stimulus.
// Bounding-box checks are compiled in when CENTROID_BBOX_EN is defined.
module tb_blob_centroid;

    logic        clock = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        pixel;
    logic        pend;

    logic [10:0] cx [2];
    logic [9:0]  cy [2];
    logic        found [2];
    logic        valid [2];
    logic        busy [2];
    logic        overrun [2];
`ifdef CENTROID_BBOX_EN
    logic [10:0] bxmin [2];
    logic [10:0] bxmax [2];
    logic [9:0]  bymin [2];
    logic [9:0]  bymax [2];
`endif

    int tests = 0;
    int fails = 0;
    int lat_seen [2];
    int nval [2];
    int nbusy [2];
    int ov11 [2];
    int ov12 [2];

    typedef struct {
        int lat; int found; int cx; int cy;
        int xmin; int xmax; int ymin; int ymax;
    } exp_t;

    typedef struct {
        int x0; int y0; int w; int h;
        exp_t e0; exp_t e1;
    } vec_t;

    vec_t vecs [5];
    vec_t post;

    always #5 clock = ~clock;

    blob_centroid #(.MIN_COUNT(64)) u_dut0 (
        .clock(clock), .reset(reset), .hcount(hcount), .vcount(vcount), .pixel(pixel),
        .centroid_x(cx[0]), .centroid_y(cy[0]), .found(found[0]), .valid(valid[0]),
        .busy(busy[0]), .overrun(overrun[0])
`ifdef CENTROID_BBOX_EN
        , .bbox_xmin(bxmin[0]), .bbox_xmax(bxmax[0]), .bbox_ymin(bymin[0]), .bbox_ymax(bymax[0])
`endif
    );

    blob_centroid #(.MIN_COUNT(1)) u_dut1 (
        .clock(clock), .reset(reset), .hcount(hcount), .vcount(vcount), .pixel(pixel),
        .centroid_x(cx[1]), .centroid_y(cy[1]), .found(found[1]), .valid(valid[1]),
        .busy(busy[1]), .overrun(overrun[1])
`ifdef CENTROID_BBOX_EN
        , .bbox_xmin(bxmin[1]), .bbox_xmax(bxmax[1]), .bbox_ymin(bymin[1]), .bbox_ymax(bymax[1])
`endif
    );

    function automatic exp_t ex(int lat, int f, int x, int y, int a, int b, int c, int d);
        exp_t e;
        e.lat = lat; e.found = f; e.cx = x; e.cy = y;
        e.xmin = a; e.xmax = b; e.ymin = c; e.ymax = d;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Coordinates go out now; the pixel bit for them follows one cycle later.
    task automatic step(input int h, input int v, input bit p);
        @(posedge clock);
        #1;
        hcount = 11'(h);
        vcount = 10'(v);
        pixel  = pend;
        pend   = p;
    endtask

    task automatic send_frame(input int x0, input int y0, input int w, input int h);
        step(0, 0, 1'b0);
        for (int y = y0; y < y0 + h; y++) begin
            for (int x = x0; x < x0 + w; x++) begin
                step(x, y, 1'b1);
            end
        end
        step(1029, 5, 1'b0);
        step(0, 768, 1'b0);
    endtask

    // 70-cycle observation window after the frame-end coordinates; optional overrun injection.
    task automatic window(input bit inject);
        for (int d = 0; d < 2; d++) begin
            lat_seen[d] = -1; nval[d] = 0; nbusy[d] = 0; ov11[d] = -1; ov12[d] = -1;
        end
        for (int k = 1; k <= 70; k++) begin
            if (inject && k <= 8)       step(500, 500, 1'b1);
            else if (inject && k == 9)  step(1029, 5, 1'b0);
            else if (inject && k == 10) step(0, 768, 1'b0);
            else                        step(5, 769, 1'b0);
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                if (valid[d]) begin
                    nval[d]++;
                    if (lat_seen[d] < 0) lat_seen[d] = k - 1;
                end
                if (busy[d]) nbusy[d]++;
                if (k == 11) ov11[d] = int'(overrun[d]);
                if (k == 12) ov12[d] = int'(overrun[d]);
            end
        end
    endtask

    task automatic check_dut(input string tag, input int d, input exp_t e);
        string p;
        p = $sformatf("%s d%0d", tag, d);
        chk({p, " latency"}, lat_seen[d], e.lat);
        chk({p, " valid_pulses"}, nval[d], 1);
        chk({p, " busy_cycles"}, nbusy[d], (e.lat == 61) ? 60 : 0);
        chk({p, " found"}, int'(found[d]), e.found);
        chk({p, " centroid_x"}, int'(cx[d]), e.cx);
        chk({p, " centroid_y"}, int'(cy[d]), e.cy);
`ifdef CENTROID_BBOX_EN
        chk({p, " bbox_xmin"}, int'(bxmin[d]), e.xmin);
        chk({p, " bbox_xmax"}, int'(bxmax[d]), e.xmax);
        chk({p, " bbox_ymin"}, int'(bymin[d]), e.ymin);
        chk({p, " bbox_ymax"}, int'(bymax[d]), e.ymax);
`endif
    endtask

    task automatic run_vector(input string tag, input vec_t v);
        send_frame(v.x0, v.y0, v.w, v.h);
        window(1'b0);
        check_dut(tag, 0, v.e0);
        check_dut(tag, 1, v.e1);
    endtask

    task automatic check_cleared(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d centroid_x", tag, d), int'(cx[d]), 0);
            chk($sformatf("%s d%0d centroid_y", tag, d), int'(cy[d]), 0);
            chk($sformatf("%s d%0d found", tag, d), int'(found[d]), 0);
            chk($sformatf("%s d%0d valid", tag, d), int'(valid[d]), 0);
            chk($sformatf("%s d%0d busy", tag, d), int'(busy[d]), 0);
            chk($sformatf("%s d%0d overrun", tag, d), int'(overrun[d]), 0);
        end
    endtask

    initial begin
        // {x0, y0, w, h} rectangles; dut0 has MIN_COUNT=64, dut1 has MIN_COUNT=1.
        vecs[0] = '{x0:0, y0:0, w:0, h:0,
                    e0:ex(1, 0, 0, 0, 0, 0, 0, 0),
                    e1:ex(1, 0, 0, 0, 0, 0, 0, 0)};
        vecs[1] = '{x0:100, y0:50, w:1, h:1,
                    e0:ex(1, 0, 0, 0, 0, 0, 0, 0),
                    e1:ex(61, 1, 100, 50, 100, 100, 50, 50)};
        vecs[2] = '{x0:200, y0:300, w:10, h:10,
                    e0:ex(61, 1, 204, 304, 200, 209, 300, 309),
                    e1:ex(61, 1, 204, 304, 200, 209, 300, 309)};
        vecs[3] = '{x0:10, y0:20, w:8, h:5,
                    e0:ex(1, 0, 204, 304, 200, 209, 300, 309),
                    e1:ex(61, 1, 13, 22, 10, 17, 20, 24)};
        vecs[4] = '{x0:1020, y0:764, w:8, h:8,
                    e0:ex(1, 0, 204, 304, 200, 209, 300, 309),
                    e1:ex(61, 1, 1021, 765, 1020, 1023, 764, 767)};

        reset = 1'b0; hcount = 11'd0; vcount = 10'd0; pixel = 1'b0; pend = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_cleared("reset_state");
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_vector($sformatf("vec%0d", i), vecs[i]);
        end
        chk("no_overrun d0", int'(overrun[0]), 0);
        chk("no_overrun d1", int'(overrun[1]), 0);

        // Second frame end at E+10 while dividing: discarded, sticky overrun.
        send_frame(200, 300, 10, 10);
        window(1'b1);
        check_dut("overrun", 0, vecs[2].e0);
        check_dut("overrun", 1, vecs[2].e1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("overrun d%0d before", d), ov11[d], 0);
            chk($sformatf("overrun d%0d set", d), ov12[d], 1);
        end

        // Accumulators must have cleared at the discarded frame end.
        post = vecs[1];
        post.e0 = vecs[3].e0;
        run_vector("post_overrun", post);
        chk("overrun_sticky d0", int'(overrun[0]), 1);
        chk("overrun_sticky d1", int'(overrun[1]), 1);

        // Reset asserted in cycle E+20, mid-DIV_X.
        send_frame(200, 300, 10, 10);
        nval[0] = 0;
        for (int k = 1; k <= 22; k++) begin
            step(5, 769, 1'b0);
            if (k == 21) reset = 1'b0;
            @(negedge clock);
            if (valid[0] || valid[1]) nval[0]++;
            if (k == 21) begin
                chk("midreset busy_before d0", int'(busy[0]), 1);
                chk("midreset busy_before d1", int'(busy[1]), 1);
            end
        end
        chk("midreset no_valid", nval[0], 0);
        check_cleared("midreset");
        reset = 1'b1;
        step(5, 769, 1'b0);
        step(5, 769, 1'b0);
        run_vector("after_reset", vecs[2]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
